// File: rtl/seven_seg_capture.sv
// Seven-segment display sniffer: samples a multiplexed
// seg/AN bus and rebuilds the four displayed MM:SS digits.
module seven_seg_capture #(
  parameter int STABLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic       CLK100MHZ,
  input  logic       reset,
  input  logic [6:0] seg,
  input  logic [7:0] AN,
  input  logic       clear_error,
  output logic [3:0] second_ones,
  output logic [3:0] second_tens,
  output logic [3:0] minute_ones,
  output logic [3:0] minute_tens,
  output logic       frame_valid,
  output logic       decode_error,
  output logic       stale
);

  localparam int SW = $clog2(STABLE_CYCLES + 2);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SW-1:0] S_THR = SW'(STABLE_CYCLES);
  localparam logic [SW-1:0] S_MAX = SW'(STABLE_CYCLES + 1);
  localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    HELD
  } state_t;

  state_t state, nxt;

  logic [7:0]      an_q;
  logic [6:0]      seg_q;
  logic [SW-1:0]   s_cnt;
  logic [TW-1:0]   t_cnt;
  logic [3:0][3:0] slot;
  logic [3:0]      mask;
  logic            same;
  logic            chg;
  logic            vsel;
  logic            bad_an;
  logic [1:0]      idx;
  logic [3:0]      digit;
  logic            legal;
  logic            capture;
  logic            new_err;

  assign same = ({AN, seg} == {an_q, seg_q});
  assign chg  = (s_cnt == SW'(1));

  // Register the bus; count how long the registered value has held.
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      an_q  <= 8'hFF;
      seg_q <= 7'h7F;
      s_cnt <= '0;
      t_cnt <= '0;
    end else begin
      an_q  <= AN;
      seg_q <= seg;
      if (!same) begin
        s_cnt <= SW'(1);
        t_cnt <= TW'(1);
      end else begin
        if (s_cnt != S_MAX) s_cnt <= s_cnt + 1'b1;
        if (t_cnt != T_MAX) t_cnt <= t_cnt + 1'b1;
      end
    end
  end

  // Anode classification: one-hot low on [3:0], [7:4] idle.
  always_comb begin
    vsel = 1'b0;
    idx  = 2'd0;
    if (an_q[7:4] == 4'hF) begin
      case (an_q[3:0])
        4'hE: begin vsel = 1'b1; idx = 2'd0; end
        4'hD: begin vsel = 1'b1; idx = 2'd1; end
        4'hB: begin vsel = 1'b1; idx = 2'd2; end
        4'h7: begin vsel = 1'b1; idx = 2'd3; end
        default: vsel = 1'b0;
      endcase
    end
    bad_an = !vsel && (an_q != 8'hFF);
  end

  // Segment pattern to BCD digit; blank maps to 4'hF.
  always_comb begin
    digit = 4'hF;
    legal = 1'b1;
    unique case (seg_q)
      7'h40: digit = 4'd0;
      7'h79: digit = 4'd1;
      7'h24: digit = 4'd2;
      7'h30: digit = 4'd3;
      7'h19: digit = 4'd4;
      7'h12: digit = 4'd5;
      7'h02: digit = 4'd6;
      7'h78: digit = 4'd7;
      7'h00: digit = 4'd8;
      7'h10: digit = 4'd9;
      7'h7F: digit = 4'hF;
      default: legal = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge CLK100MHZ) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  // Next state; capture fires once on entry to HELD.
  always_comb begin
    nxt     = state;
    capture = 1'b0;
    case (state)
      IDLE: begin
        if (vsel) nxt = SETTLE;
      end
      SETTLE: begin
        if (chg) begin
          nxt = vsel ? SETTLE : IDLE;
        end else if (!vsel) begin
          nxt = IDLE;
        end else if (s_cnt >= S_THR) begin
          nxt     = HELD;
          capture = 1'b1;
        end
      end
      HELD: begin
        if (chg) nxt = vsel ? SETTLE : IDLE;
      end
      default: nxt = IDLE;
    endcase
    new_err = (capture && !legal) ||
              (bad_an && s_cnt == S_THR);
  end

  // Slots, seen mask, frame output and status flags.
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      slot         <= '0;
      mask         <= '0;
      second_ones  <= '0;
      second_tens  <= '0;
      minute_ones  <= '0;
      minute_tens  <= '0;
      frame_valid  <= 1'b0;
      decode_error <= 1'b0;
      stale        <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      if (new_err)          decode_error <= 1'b1;
      else if (clear_error) decode_error <= 1'b0;
      if (mask == 4'hF) begin
        second_ones <= slot[0];
        second_tens <= slot[1];
        minute_ones <= slot[2];
        minute_tens <= slot[3];
        frame_valid <= 1'b1;
        mask        <= '0;
      end else if (capture && legal) begin
        slot[idx] <= digit;
        mask[idx] <= 1'b1;
      end else if (t_cnt == T_MAX) begin
        mask <= '0;
      end
      if (capture && legal)    stale <= 1'b0;
      else if (t_cnt == T_MAX) stale <= 1'b1;
    end
  end

endmodule

// File: tb/tb_seven_seg_capture.sv
// Scoreboard bench for seven_seg_capture: segment-level
// reference model, frames checked by an independent monitor.
module tb_seven_seg_capture;

  localparam int STB = 4;
  localparam int TMO = 64;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] seg;
  logic [7:0] AN;
  logic       clear_error;
  logic [3:0] second_ones, second_tens;
  logic [3:0] minute_ones, minute_tens;
  logic       frame_valid, decode_error, stale;

  seven_seg_capture #(
    .STABLE_CYCLES (STB),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .CLK100MHZ   (clk),
    .reset       (reset),
    .seg         (seg),
    .AN          (AN),
    .clear_error (clear_error),
    .second_ones (second_ones),
    .second_tens (second_tens),
    .minute_ones (minute_ones),
    .minute_tens (minute_tens),
    .frame_valid (frame_valid),
    .decode_error(decode_error),
    .stale       (stale)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [15:0] frq[$];
  logic [3:0]  m_slot[4];
  logic [3:0]  m_out[4];
  logic [3:0]  m_mask;
  logic        m_err, m_stale;
  logic [14:0] prev;
  logic [6:0]  pats[10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                            7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  logic [7:0]  valid_an[4] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7};
  logic [7:0]  bad_an[4]   = '{8'hFC, 8'h7E, 8'hF0, 8'hEF};
  logic [6:0]  ill_seg[4]  = '{7'h55, 7'h7E, 7'h01, 7'h3C};

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int slot_of(input logic [7:0] an);
    for (int i = 0; i < 4; i++)
      if (an == valid_an[i]) return i;
    return -1;
  endfunction

  function automatic int dec(input logic [6:0] s);
    for (int i = 0; i < 10; i++)
      if (s == pats[i]) return i;
    if (s == 7'h7F) return 15;
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_slot[i] = '0;
      m_out[i]  = '0;
    end
    m_mask  = '0;
    m_err   = 1'b0;
    m_stale = 1'b0;
    prev    = {8'hFF, 7'h7F};
  endtask

  task automatic model_seg(input logic [7:0] an, input logic [6:0] s,
                           input int len, input bit clr);
    int k, d;
    if (clr) m_err = 1'b0;
    k = slot_of(an);
    if (len >= STB) begin
      if (k >= 0) begin
        d = dec(s);
        if (d < 0) begin
          m_err = 1'b1;
        end else begin
          m_slot[k] = d[3:0];
          m_mask[k] = 1'b1;
          m_stale   = 1'b0;
          if (m_mask == 4'hF) begin
            for (int i = 0; i < 4; i++) m_out[i] = m_slot[i];
            frq.push_back({m_slot[3], m_slot[2], m_slot[1], m_slot[0]});
            m_mask = '0;
          end
        end
      end else if (an != 8'hFF) begin
        m_err = 1'b1;
      end
    end
    if (len > TMO) begin
      m_stale = 1'b1;
      m_mask  = '0;
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, " second_ones"}, second_ones, m_out[0]);
    chk({tag, " second_tens"}, second_tens, m_out[1]);
    chk({tag, " minute_ones"}, minute_ones, m_out[2]);
    chk({tag, " minute_tens"}, minute_tens, m_out[3]);
    chk({tag, " decode_error"}, decode_error, m_err);
    chk({tag, " stale"}, stale, m_stale);
  endtask

  task automatic run_seg(input logic [7:0] an, input logic [6:0] s,
                         input int len, input bit clr, input string tag);
    model_seg(an, s, len, clr);
    prev = {an, s};
    for (int i = 0; i < len; i++) begin
      AN          = an;
      seg         = s;
      clear_error = clr && (i == 0);
      @(negedge clk);
    end
    clear_error = 1'b0;
    check_state(tag);
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    AN          = 8'hFF;
    seg         = 7'h7F;
    clear_error = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  // Monitor: every frame_valid pulse must match the next queued frame.
  always @(negedge clk) begin
    if (!reset && frame_valid) begin
      if (frq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_frame: got %h%h%h%h expected none",
                 minute_tens, minute_ones, second_tens, second_ones);
      end else begin
        logic [15:0] e;
        e = frq.pop_front();
        chk("frame", {minute_tens, minute_ones, second_tens, second_ones}, e);
      end
    end
  end

  initial begin
    logic [7:0] an;
    logic [6:0] s;
    int len, r;
    bit seen;
    do_reset();
    check_state("reset");
    chk("reset frame_valid", frame_valid, 0);

    run_seg(8'hFE, 7'h12, 8, 0, "scan0");
    run_seg(8'hFD, 7'h19, 8, 0, "scan1");
    run_seg(8'hFB, 7'h30, 8, 0, "scan2");
    run_seg(8'hF7, 7'h79, 8, 0, "scan3");
    run_seg(8'hFF, 7'h7F, 6, 0, "scan_blank");
    chk("scan digits", {minute_tens, minute_ones, second_tens, second_ones},
        16'h1345);

    run_seg(8'hFE, 7'h40, 8, 0, "short0");
    run_seg(8'hFD, 7'h79, 3, 0, "short1");
    run_seg(8'hFB, 7'h24, 8, 0, "short2");
    run_seg(8'hF7, 7'h30, 8, 0, "short3");
    run_seg(8'hFF, 7'h7F, 6, 0, "short_blank");
    chk("short no frame", second_tens, 4);
    run_seg(8'hFD, 7'h19, 8, 0, "short_fill");

    run_seg(8'hFE, 7'h7F, 8, 0, "blank_digit");
    run_seg(8'hFD, 7'h40, 8, 0, "blank1");
    run_seg(8'hFB, 7'h40, 8, 0, "blank2");
    run_seg(8'hF7, 7'h40, 8, 0, "blank3");
    run_seg(8'hFF, 7'h7F, 6, 0, "blank_end");
    chk("blank slot", second_ones, 15);
    run_seg(8'hFE, 7'h55, 8, 0, "illegal");
    chk("illegal err", decode_error, 1);
    run_seg(8'hFF, 7'h7F, 6, 0, "illegal_hold");
    run_seg(8'hFE, 7'h40, 8, 1, "illegal_clr");

    run_seg(8'hFC, 7'h40, 8, 0, "two_an");
    chk("two_an err", decode_error, 1);
    run_seg(8'hFF, 7'h7F, 20, 1, "all_high");
    chk("all_high err", decode_error, 0);

    // Clear held through an error: the error must still show.
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      AN = 8'hFC; seg = 7'h12; clear_error = 1'b1;
      @(negedge clk);
      if (decode_error) seen = 1;
    end
    clear_error = 1'b0;
    prev = {8'hFC, 7'h12};
    chk("err beats clear", seen, 1);

    run_seg(8'hFE, 7'h12, 70, 0, "stale_hold");
    chk("stale set", stale, 1);
    run_seg(8'hFD, 7'h19, 8, 0, "stale_cap");
    chk("stale cleared", stale, 0);
    run_seg(8'hFB, 7'h30, 8, 0, "stale2");
    run_seg(8'hF7, 7'h79, 8, 0, "stale3");
    run_seg(8'hFE, 7'h02, 8, 0, "stale0");
    run_seg(8'hFF, 7'h7F, 6, 0, "stale_end");

    run_seg(8'hFE, 7'h78, 8, 0, "rst0");
    run_seg(8'hFD, 7'h00, 8, 0, "rst1");
    run_seg(8'hFB, 7'h10, 8, 0, "rst2");
    do_reset();
    check_state("midreset");
    run_seg(8'hFE, 7'h79, 8, 0, "post0");
    run_seg(8'hFD, 7'h24, 8, 0, "post1");
    run_seg(8'hFB, 7'h30, 8, 0, "post2");
    check_state("post_partial");
    run_seg(8'hF7, 7'h19, 8, 0, "post3");
    run_seg(8'hFF, 7'h7F, 6, 0, "post_end");

    for (int n = 0; n < 200; n++) begin
      do begin
        r = $urandom_range(0, 15);
        if (r <= 10)      an = valid_an[$urandom_range(0, 3)];
        else if (r <= 12) an = 8'hFF;
        else              an = bad_an[$urandom_range(0, 3)];
        r = $urandom_range(0, 13);
        if (r <= 11)      s = pats[$urandom_range(0, 9)];
        else if (r == 12) s = 7'h7F;
        else              s = ill_seg[$urandom_range(0, 3)];
      end while ({an, s} == prev);
      r = $urandom_range(0, 19);
      if (r <= 3)       len = $urandom_range(1, 3);
      else if (r <= 18) len = $urandom_range(6, 12);
      else              len = $urandom_range(70, 80);
      run_seg(an, s, len, ($urandom_range(0, 7) == 0), "rand");
    end

    repeat (10) @(negedge clk);
    chk("frames drained", frq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seven_seg_capture.md
SEVEN_SEG_CAPTURE -- requirements
Module: seven_seg_capture

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 16: consecutive identical samples needed to accept a digit slot.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1_000_000: idle samples before the captured frame is declared stale.
REQ-003 SHALL have port CLK100MHZ  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port seg  input  7  active-low segments, seg[0]=a ... seg[6]=g.
REQ-006 SHALL have port AN  input  8  active-low anodes; AN[0]=seconds ones, AN[1]=seconds tens, AN[2]=minutes ones, AN[3]=minutes tens; AN[7:4] are unused.
REQ-007 SHALL have port clear_error  input  1  clears decode_error.
REQ-008 SHALL have ports second_ones, second_tens, minute_ones, minute_tens  output  4 each  last complete decoded frame.
REQ-009 SHALL have port frame_valid  output  1  one-cycle pulse when the digit outputs update.
REQ-010 SHALL have port decode_error  output  1  sticky fault flag.
REQ-011 SHALL have port stale  output  1  level; no anode activity for TIMEOUT_CYCLES.

Function
REQ-012 SHALL register {AN,seg} once before use; all behaviour refers to this registered sample.
REQ-013 SHALL treat a sample as a valid select when AN[7:4]=4'hF and exactly one bit of AN[3:0] is 0.
REQ-014 SHALL decode seg as follows:
- 40=0, 79=1, 24=2, 30=3, 19=4, 12=5, 02=6, 78=7, 00=8, 10=9.
- 7F (blank) = 4'hF.
- Any other pattern is illegal.
REQ-015 SHALL implement states IDLE, SETTLE and HELD:
- IDLE -> SETTLE on a valid select.
- SETTLE -> HELD when the sample has been identical for STABLE_CYCLES consecutive cycles.
- SETTLE -> IDLE, or SETTLE restarting with count 1, when the sample changes.
- HELD -> IDLE/SETTLE on any sample change.
REQ-016 SHALL capture a digit on entry to HELD, exactly once per HELD visit, into the slot selected by AN, and set that slot's bit in a 4-bit seen mask.
REQ-017 SHALL, on capture of an illegal pattern, set decode_error, leave the slot and mask unchanged, and not capture.
REQ-018 SHALL set decode_error when a sample with more than one AN[3:0] bit low, or any AN[7:4] bit low, persists for STABLE_CYCLES cycles; all-anodes-high SHALL be normal blanking and not an error.
REQ-019 SHALL, the cycle after the mask reaches 4'hF, copy all four slots to the outputs in one cycle, pulse frame_valid for one cycle, and clear the mask.
REQ-020 SHALL overwrite a slot already seen in the current frame with the newer value, without producing an early frame.
REQ-021 SHALL count cycles since the last change of the registered sample; at TIMEOUT_CYCLES it SHALL assert stale and clear the mask.
REQ-022 SHALL deassert stale on the next capture; digit outputs SHALL hold their value while stale.
REQ-023 SHALL clear decode_error when clear_error=1; a new error in the same cycle SHALL win, leaving decode_error=1.
REQ-024 SHALL saturate the stability counter and the timeout counter; neither SHALL wrap.

Reset
REQ-025 SHALL, on reset, set the state to IDLE, clear all slots, the mask and all counters, and drive digit outputs=0, frame_valid=0, decode_error=0, stale=0.
REQ-026 SHALL give reset priority over all other inputs; a reset mid-frame SHALL discard partial captures without a frame_valid pulse.

Verification (bench: STABLE_CYCLES=4, TIMEOUT_CYCLES=64)
REQ-027 SHALL cover: scan AN=FE/FD/FB/F7 with seg=12/19/30/79, 8 cycles each -> one frame_valid pulse; second_ones=5, second_tens=4, minute_ones=3, minute_tens=1.
REQ-028 SHALL cover: one slot held only 3 cycles between 8-cycle slots -> no capture for that slot, no frame_valid.
REQ-029 SHALL cover: seg=7F with AN=FE for 8 cycles -> slot 0 = 4'hF, decode_error=0; seg=0x55 with AN=FE for 8 cycles -> decode_error=1 until clear_error.
REQ-030 SHALL cover: AN=FC for 8 cycles -> decode_error=1, no capture; AN=FF for 20 cycles -> no error.
REQ-031 SHALL cover: constant sample held for 64 cycles -> stale=1, outputs unchanged; a full scan afterward -> stale=0, then frame_valid.
REQ-032 SHALL cover: reset asserted after 3 of 4 slots are captured -> all outputs 0, and no frame_valid until 4 new captures complete.
